lif_scheduler: RTL

Time-multiplexes one leaky-integrate-fire update datapath across NUM_NEURONS neurons. Each tick it sweeps all neurons in index order: it fetches each neuron's input current over a request/valid handshake, applies the leak/integrate/fire update, and writes the membrane state back. Spike events are emitted as indexed pulses. It sits between the stimulus/current source and the spike-event consumer, and owns the shared threshold and refractory configuration.

---
 rtl/lif_pkg.sv | 17 +
 rtl/lif_update.sv | 36 +++
 rtl/lif_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky-integrate-fire scheduler.
package lif_pkg;

    localparam int CUR_W         = 4;
    localparam int STATE_W       = 8;
    localparam int REF_W         = 2;
    localparam int DEF_THRESHOLD = 127;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } lif_state_t;

endpackage

// File: rtl/lif_update.sv
// Combinational LIF neuron update: leak by halving, integrate current, fire on threshold.
// Zero latency; no handshake (pure function of its inputs).
module lif_update #(
    parameter int CUR_W        = lif_pkg::CUR_W,
    parameter int STATE_W      = lif_pkg::STATE_W,
    parameter int REF_W        = lif_pkg::REF_W,
    parameter int REFRAC_TICKS = 2
) (
    input  logic [STATE_W-1:0] s,
    input  logic [REF_W-1:0]   r,
    input  logic [CUR_W-1:0]   c,
    input  logic [STATE_W-1:0] threshold,
    output logic [STATE_W-1:0] s_next,
    output logic [REF_W-1:0]   r_next,
    output logic               fire
);

    logic [STATE_W-1:0] n;

    always_comb begin
        n      = STATE_W'(c) + (s >> 1);
        s_next = n;
        r_next = r;
        fire   = 1'b0;
        if (r != '0) begin
            // refractory neurons discard input and stay discharged
            s_next = '0;
            r_next = r - 1'b1;
        end else if (n >= threshold) begin
            fire   = 1'b1;
            s_next = '0;
            r_next = REF_W'(REFRAC_TICKS);
        end
    end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps NUM_NEURONS neurons per tick through one shared LIF datapath; 3 cycles/neuron + 1.
// Waits indefinitely for cur_valid; ticks arriving while busy are dropped and flagged in overrun.
module lif_scheduler #(
    parameter int NUM_NEURONS  = 8,
    parameter int IDX_W        = 3,
    parameter int CUR_W        = 4,
    parameter int STATE_W      = 8,
    parameter int REFRAC_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    output logic               cur_req,
    output logic [IDX_W-1:0]   cur_idx,
    input  logic [CUR_W-1:0]   current,
    input  logic               cur_valid,
    output logic               spike_valid,
    output logic [IDX_W-1:0]   spike_idx,
    output logic               sweep_done,
    output logic               busy,
    output logic               overrun,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_threshold,
    input  logic               clr_overrun
);

    import lif_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    lif_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [CUR_W-1:0]   cur_q;
    logic [STATE_W-1:0] threshold_q;
    logic [STATE_W-1:0] mem_state [NUM_NEURONS];
    logic [REF_W-1:0]   mem_ref   [NUM_NEURONS];
    logic               overrun_q;
    logic               spike_valid_q;
    logic [IDX_W-1:0]   spike_idx_q;

    logic [STATE_W-1:0] s_next;
    logic [REF_W-1:0]   r_next;
    logic               fire;

    lif_update #(
        .CUR_W        (CUR_W),
        .STATE_W      (STATE_W),
        .REF_W        (REF_W),
        .REFRAC_TICKS (REFRAC_TICKS)
    ) u_update (
        .s         (mem_state[idx_q]),
        .r         (mem_ref[idx_q]),
        .c         (cur_q),
        .threshold (threshold_q),
        .s_next    (s_next),
        .r_next    (r_next),
        .fire      (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tick) state_d = S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT:   if (cur_valid) state_d = S_UPDATE;
            S_UPDATE: state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            cur_q       <= '0;
            threshold_q <= STATE_W'(DEF_THRESHOLD);
        end else begin
            if (state_q == S_IDLE && tick) begin
                idx_q <= '0;
            end else if (state_q == S_UPDATE && idx_q != LAST_IDX) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == S_WAIT && cur_valid) begin
                cur_q <= current;
            end
            // threshold only moves between sweeps so a sweep sees one value
            if (state_q == S_IDLE && cfg_we) begin
                threshold_q <= cfg_threshold;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_state[i] <= '0;
                mem_ref[i]   <= '0;
            end
        end else if (state_q == S_UPDATE) begin
            mem_state[idx_q] <= s_next;
            mem_ref[idx_q]   <= r_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
        end else begin
            spike_valid_q <= (state_q == S_UPDATE) && fire;
            if (state_q == S_UPDATE && fire) begin
                spike_idx_q <= idx_q;
            end
        end
    end

    // a dropped tick outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (tick && state_q != S_IDLE) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    always_comb begin
        cur_req     = (state_q == S_FETCH);
        cur_idx     = idx_q;
        sweep_done  = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        overrun     = overrun_q;
        spike_valid = spike_valid_q;
        spike_idx   = spike_idx_q;
    end

endmodule
